// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file geometry, dump FSM states and word types
package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam int N_REGS = 32;
  localparam logic [ADDR_W-1:0] XZR_IDX = 5'd31;
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} dump_state_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: walks the register file through read port 1 and streams every word with an XOR checksum
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int N_REGS = regfile_pkg::N_REGS,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cpu_ra,
  output logic [DATA_W-1:0] cpu_rd,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_idx,
  output logic              dout_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_REGS - 1);
  dump_state_t state;
  logic [ADDR_W-1:0] idx;
  assign busy   = state != IDLE;
  assign done   = state == DONE;
  assign rf_ra  = busy ? idx : cpu_ra;
  assign cpu_rd = busy ? '0 : rf_rd;
  // dump sequencer: latch one word per READ, hold it in SEND until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_idx   <= '0;
      dout_last  <= 1'b0;
      checksum   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= READ;
          idx      <= '0;
          checksum <= '0;
        end
        READ: begin
          dout_data  <= rf_rd;
          dout_idx   <= idx;
          dout_last  <= idx == LAST_IDX;
          dout_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: if (dout_valid && dout_ready) begin
          checksum   <= checksum ^ dout_data;
          dout_valid <= 1'b0;
          state      <= dout_last ? DONE : READ;
          idx        <= dout_last ? idx : idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized dumps of a behavioural regfile checked against a word-list reference
module tb_regfile_dump;
  logic        clk = 0, reset = 1, start = 0, dout_ready = 1;
  logic [4:0]  cpu_ra = 0, rf_ra, dout_idx;
  logic [63:0] cpu_rd, rf_rd, dout_data, checksum;
  logic        dout_valid, dout_last, busy, done;
  logic        we3 = 0;
  logic [4:0]  wa3 = 0;
  logic [63:0] wd3 = 0;
  logic [63:0] mem [32];
  logic [63:0] ref_x [32];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (we3 && wa3 != 5'd31) mem[wa3] <= wd3;
  assign rf_rd = (rf_ra == 5'd31) ? 64'd0 : mem[rf_ra];

  regfile_dump dut (
    .clk(clk), .reset(reset), .start(start), .cpu_ra(cpu_ra), .cpu_rd(cpu_rd),
    .rf_ra(rf_ra), .rf_rd(rf_rd), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_data(dout_data), .dout_idx(dout_idx), .dout_last(dout_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [63:0] d);
    we3 = 1; wa3 = a; wd3 = d;
    step();
    we3 = 0;
    if (a != 5'd31) ref_x[a] = d;
  endtask

  // mode 0: ready high, 1: random ready, 2: start re-pulsed at idx 10, 3: reset in SEND at idx 12
  task automatic run_dump(input int mode, output logic [63:0] xs);
    logic [63:0] exp_w [32];
    logic [63:0] hd;
    logic [4:0]  hi;
    logic        hold, r;
    int k, dones, cyc, done_cyc;
    xs = 0; k = 0; dones = 0; cyc = 0; done_cyc = 0; hold = 0; hd = 0; hi = 0;
    for (int i = 0; i < 32; i++) begin
      exp_w[i] = (i == 31) ? 64'd0 : ref_x[i];
      xs ^= exp_w[i];
    end
    start = 1;
    step();
    start = 0;
    while (cyc < 400) begin
      cyc++;
      if (done) begin
        dones++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (hold) begin
        check("hold_valid", 64'(dout_valid), 64'd1);
        check("hold_data", dout_data, hd);
        check("hold_idx", 64'(dout_idx), 64'(hi));
      end
      if (dones == 0) begin
        check("busy_in_dump", 64'(busy), 64'd1);
        check("cpu_rd_in_dump", cpu_rd, 64'd0);
      end
      if (done_cyc != 0 && cyc == done_cyc + 2) break;
      r = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      dout_ready = r;
      cpu_ra = 5'($urandom);
      start = (mode == 2 && dout_valid && dout_idx == 5'd10);
      if (mode == 3 && dout_valid && dout_idx == 5'd12) begin
        reset = 1;
        step();
        reset = 0;
        check("abort_valid", 64'(dout_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_checksum", checksum, 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_words", 64'(k), 64'd12);
        check("abort_dones", 64'(dones), 64'd0);
        return;
      end
      if (dout_valid && r) begin
        check("word_idx", 64'(dout_idx), 64'(k));
        check("word_data", dout_data, exp_w[k % 32]);
        check("word_last", 64'(dout_last), 64'(k == 31));
        k++;
      end
      hold = dout_valid && !r;
      hd = dout_data;
      hi = dout_idx;
      step();
    end
    start = 0;
    dout_ready = 1;
    check("word_count", 64'(k), 64'd32);
    check("done_pulses", 64'(dones), 64'd1);
    check("checksum", checksum, xs);
    check("idle_after", 64'(busy), 64'd0);
    if (mode == 0) check("done_cycle", 64'(done_cyc), 64'd65);
  endtask

  initial begin
    logic [63:0] xs;
    for (int i = 0; i < 32; i++) ref_x[i] = 64'(i);
    ref_x[31] = 0;
    for (int i = 0; i < 31; i++) cpu_write(5'(i), 64'(i));
    step();
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_data", dout_data, 64'd0);
    check("rst_idx", 64'(dout_idx), 64'd0);
    check("rst_last", 64'(dout_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_checksum", checksum, 64'd0);
    reset = 0;
    cpu_ra = 5'd7;
    #1;
    check("pass_ra", 64'(rf_ra), 64'd7);
    check("pass_rd", cpu_rd, 64'd7);
    cpu_ra = 5'd31;
    #1;
    check("pass_xzr", cpu_rd, 64'd0);
    step();
    run_dump(0, xs);
    check("checksum_init", checksum, 64'd31);
    for (int n = 0; n < 3; n++) begin
      run_dump(1, xs);
      check("checksum_bp", checksum, 64'd31);
    end
    repeat (3) step();
    check("checksum_hold", checksum, 64'd31);
    cpu_write(5'd3, 64'hDEAD_BEEF);
    run_dump(0, xs);
    check("checksum_write", checksum, 64'd31 ^ 64'd3 ^ 64'hDEAD_BEEF);
    run_dump(2, xs);
    run_dump(3, xs);
    run_dump(1, xs);
    check("checksum_after_abort", checksum, 64'd31 ^ 64'd3 ^ 64'hDEAD_BEEF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Sequential read-side initiator for the 32x64 register file: on `start`, walks X0..X31 through one asynchronous read port.
- Streams each word out on a valid/ready interface and accumulates an XOR checksum.
- Sits between the CPU read-address path and the register file read port 1.
- While idle it is a transparent pass-through for the CPU. Used for debug dumps and post-program state checks on the board.

Parameters:
- N_REGS, 32, number of registers walked (X0..X(N_REGS-1)).
- ADDR_W, 5, register address width.
- DATA_W, 64, register data width.

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a dump; sampled only in IDLE
- cpu_ra  input  ADDR_W  CPU read address (pass-through when idle)
- cpu_rd  output  DATA_W  CPU read data
- rf_ra  output  ADDR_W  address driven to register file read port
- rf_rd  input  DATA_W  asynchronous data returned by register file
- dout_valid  output  1  stream word valid
- dout_ready  input  1  downstream accepts word
- dout_data  output  DATA_W  register contents
- dout_idx  output  ADDR_W  register index of dout_data
- dout_last  output  1  high with the word for index N_REGS-1
- busy  output  1  dump in progress (IDLE excluded)
- done  output  1  one-cycle pulse after last word accepted
- checksum  output  DATA_W  XOR of all words of the latest dump

Behaviour:
- Reset values:
  - state = IDLE, idx = 0
  - dout_valid = 0, dout_data = 0, dout_idx = 0, dout_last = 0
  - busy = 0, done = 0, checksum = 0
- Reset applied mid-dump aborts immediately, with no done pulse.
- Address mux (combinational):
  - IDLE: rf_ra = cpu_ra, cpu_rd = rf_rd.
  - Otherwise: rf_ra = idx, cpu_rd = 0. The CPU must stall on busy.
- State machine, states IDLE, READ, SEND, DONE:
  - IDLE:
    - start=1 -> READ; idx <= 0; checksum <= 0.
    - start=0 -> stay.
  - READ (one cycle):
    - rf_ra = idx.
    - Register dout_data <= rf_rd, dout_idx <= idx, dout_last <= (idx == N_REGS-1).
    - Set dout_valid <= 1 -> SEND.
  - SEND:
    - Hold dout_valid/dout_data/dout_idx/dout_last stable until dout_valid & dout_ready.
    - On the handshake cycle: checksum <= checksum ^ dout_data; dout_valid <= 0.
    - If dout_last -> DONE, else idx <= idx+1 -> READ.
  - DONE: done = 1 for exactly this cycle -> IDLE.
- busy = 1 in READ, SEND and DONE.
- Timing:
  - Throughput is one word per 2 cycles with dout_ready tied high.
  - With ready tied high, a full dump takes 2*N_REGS + 1 cycles from the start-sample edge to the done pulse.
- start while busy is ignored, with no queuing. start in the same cycle as done (DONE state) is ignored; it must be re-asserted in IDLE.
- dout_ready while dout_valid=0 has no effect.
- idx never wraps: it saturates at N_REGS-1 because SEND exits to DONE on dout_last.
- Register X31 (XZR) reads 0 from the register file. It is streamed like any other index, with no special case in this block.
- Writes to the register file are not touched. The write port remains CPU-owned; writes during a dump are the CPU's responsibility (CPU is stalled on busy).
- checksum holds its value after done until the next accepted start.

Decomposition:
- Package regfile_pkg:
  - ADDR_W = 5, DATA_W = 64, N_REGS = 32, XZR_IDX = 5'd31
  - typedef enum logic [1:0] {IDLE, READ, SEND, DONE} dump_state_t
  - typedefs reg_addr_t and reg_data_t
- No sub-module. Address mux, FSM and checksum register fit in one module.
- Bench instantiates regfile + regfile_dump together.

Test Plan:
1. Reset, then pulse start with dout_ready=1 and the regfile at init values (Xi = i, X31 = 0):
   - 32 words with dout_idx 0..31 and dout_data 0..30 then 0.
   - dout_last only on idx 31.
   - done pulse at cycle 65 after start.
   - checksum = 64'd31.
2. Backpressure: dout_ready toggles 1,0,0,1,... (random pattern):
   - dout_data/dout_idx stable while valid & !ready.
   - No word lost or duplicated.
   - Same 32-word sequence, checksum = 31.
3. Pass-through when idle:
   - busy=0, cpu_ra=5'd7 -> rf_ra=7, cpu_rd=64'd7.
   - During dump, cpu_ra ignored and cpu_rd=0.
4. Prior write then dump: CPU writes X3 = 64'hDEAD_BEEF via we3 before start:
   - Word idx 3 = DEAD_BEEF.
   - checksum = 31 ^ 3 ^ 64'hDEAD_BEEF.
5. start re-pulsed at idx 10 mid-dump: no restart, single done pulse, sequence unchanged.
6. reset asserted while in SEND at idx 12:
   - Next cycle: dout_valid=0, busy=0, checksum=0, no done pulse.
   - A following start produces a full dump from idx 0.
